// File: rtl/blinky_pkg.sv
// rtl/blinky_pkg.sv - shared types, register map and helpers for the LED controller
//
// Contents:
//   mode_t       channel operating mode
//   target_e     decoded register target
//   dec_t        decoded address (target + channel index)
//   decode_addr  register index -> target/channel
//   apply_strb   byte-strobe merge of write data into an old 32-bit value
package blinky_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  // Global register indices
  localparam logic [7:0] GCTRL = 8'h00;
  localparam logic [7:0] INFO  = 8'h01;
  localparam logic [7:0] FREQ  = 8'h02;

  // Channel register block
  localparam logic [7:0] CH_BASE   = 8'h10;
  localparam logic [7:0] CH_STRIDE = 8'd4;
  localparam logic [1:0] CH_MODE   = 2'd0;
  localparam logic [1:0] CH_PERIOD = 2'd1;
  localparam logic [1:0] CH_DUTY   = 2'd2;
  localparam logic [1:0] CH_CNT    = 2'd3;

  // AXI responses
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    T_GCTRL,
    T_INFO,
    T_FREQ,
    T_CH_MODE,
    T_CH_PERIOD,
    T_CH_DUTY,
    T_CH_CNT,
    T_NONE
  } target_e;

  typedef struct packed {
    target_e    tgt;
    logic [5:0] ch;
  } dec_t;

  function automatic dec_t decode_addr(input logic [7:0] addr, input int unsigned num_ch);
    dec_t       d;
    logic [7:0] rel;
    d.tgt = T_NONE;
    d.ch  = '0;
    rel   = '0;
    if (addr < CH_BASE) begin
      case (addr)
        GCTRL:   d.tgt = T_GCTRL;
        INFO:    d.tgt = T_INFO;
        FREQ:    d.tgt = T_FREQ;
        default: d.tgt = T_NONE;
      endcase
    end else begin
      rel  = addr - CH_BASE;
      d.ch = 6'(rel / CH_STRIDE);
      // Channel bases at or beyond num_ch stay unmapped
      if ({26'b0, d.ch} < num_ch) begin
        case (2'(rel % CH_STRIDE))
          CH_MODE:   d.tgt = T_CH_MODE;
          CH_PERIOD: d.tgt = T_CH_PERIOD;
          CH_DUTY:   d.tgt = T_CH_DUTY;
          default:   d.tgt = T_CH_CNT;
        endcase
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/blinky_pwm_chan.sv
// rtl/blinky_pwm_chan.sv - one LED channel: counter, wrap detect and LED flop
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           master enable; 0 holds counter and LED at 0
//   clr_i          one-cycle clear of counter and LED (mode/period written)
//   mode_i         off / solid / blink / pwm
//   period_i       period, 0 treated as 1
//   duty_i         pwm high count
//   cnt_o          current counter value
//   led_o          registered LED output
module blinky_pwm_chan
  import blinky_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  mode_t                mode_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic [CNT_WIDTH-1:0] duty_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 led_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] per_eff, last_cnt;
  logic                 led_q, led_d;
  logic                 wrap, running;

  assign per_eff  = (period_i == '0) ? CNT_WIDTH'(1) : period_i;
  assign last_cnt = per_eff - CNT_WIDTH'(1);
  // >= rather than == so a period lowered below the count wraps at once
  assign wrap     = (cnt_q >= last_cnt);
  assign running  = en_i & ((mode_i == MODE_BLINK) | (mode_i == MODE_PWM));

  always_comb begin
    cnt_d = '0;
    led_d = 1'b0;
    if (running && !clr_i) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
    end
    if (en_i && !clr_i) begin
      case (mode_i)
        MODE_SOLID: led_d = 1'b1;
        MODE_BLINK: led_d = wrap ? ~led_q : led_q;
        MODE_PWM:   led_d = (cnt_q < duty_i);
        default:    led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign cnt_o = cnt_q;
  assign led_o = led_q;

endmodule

// File: rtl/blinky_skid_buf.sv
// rtl/blinky_skid_buf.sv - 2-entry skid buffer with registered ready
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_tdata_i/tvalid_i/tready_o  upstream stream (tready is a flop, 0 in reset)
//   m_tdata_o/tvalid_o/tready_i  downstream stream (head of the buffer)
module blinky_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i
);

  logic [1:0][WIDTH-1:0] data_q, data_d;
  logic [1:0]            count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  push, pop;

  assign push       = s_tvalid_i & ready_q;
  assign pop        = m_tvalid_o & m_tready_i;
  assign m_tvalid_o = (count_q != 2'd0);
  assign m_tdata_o  = data_q[0];
  assign s_tready_o = ready_q;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (pop) begin
      data_d[0] = data_q[1];
      count_d   = count_q - 2'd1;
    end
    // After a pop the fill level is 0 or 1, which is also the free slot index
    if (push) begin
      data_d[count_d[0]] = s_tdata_i;
      count_d            = count_d + 2'd1;
    end
    // Ready is registered: the second entry absorbs the beat that arrives
    // in the cycle the downstream stalls.
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/blinky_pwm_reg.sv
// rtl/blinky_pwm_reg.sv - AXI-Lite multi-channel LED controller (off/solid/blink/pwm)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   led[NUM_CH]              registered channel outputs
//   s_axil_aw*/w*/b*         AXI-Lite write address, data, response
//   s_axil_ar*/r*            AXI-Lite read address, data
// Addresses are word indices. AW, W and AR each pass through a skid buffer.
module blinky_pwm_reg
  import blinky_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [NUM_CH-1:0] led,
  input  logic [7:0]        s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic              s_axil_bvalid,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_bready,
  input  logic [7:0]        s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic              s_axil_rvalid,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  input  logic              s_axil_rready
);

  localparam logic [CNT_WIDTH-1:0] PERIOD_RST = CNT_WIDTH'(CLK_FREQ / 2);
  localparam logic [CNT_WIDTH-1:0] DUTY_RST   = PERIOD_RST / 2;

  // Skid buffer outputs
  logic [7:0]  aw_addr, ar_addr;
  logic [35:0] w_beat;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_valid, w_valid, ar_valid;
  logic        wr_fire, rd_fire;

  // Register file
  logic                                 gctrl_q, gctrl_d;
  logic [NUM_CH-1:0][1:0]               mode_q, mode_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]     period_q, period_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]     duty_q, duty_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]     cnt_w;
  logic [NUM_CH-1:0]                    clr;

  // Response channels
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  dec_t        wr_dec, rd_dec;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;

  blinky_skid_buf #(.WIDTH(8)) u_aw_skid (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_axil_awaddr), .s_tvalid_i(s_axil_awvalid), .s_tready_o(s_axil_awready),
    .m_tdata_o(aw_addr), .m_tvalid_o(aw_valid), .m_tready_i(wr_fire)
  );

  blinky_skid_buf #(.WIDTH(36)) u_w_skid (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i({s_axil_wstrb, s_axil_wdata}), .s_tvalid_i(s_axil_wvalid), .s_tready_o(s_axil_wready),
    .m_tdata_o(w_beat), .m_tvalid_o(w_valid), .m_tready_i(wr_fire)
  );

  blinky_skid_buf #(.WIDTH(8)) u_ar_skid (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_axil_araddr), .s_tvalid_i(s_axil_arvalid), .s_tready_o(s_axil_arready),
    .m_tdata_o(ar_addr), .m_tvalid_o(ar_valid), .m_tready_i(rd_fire)
  );

  assign w_data  = w_beat[31:0];
  assign w_strb  = w_beat[35:32];
  assign wr_dec  = decode_addr(aw_addr, NUM_CH);
  assign rd_dec  = decode_addr(ar_addr, NUM_CH);

  // A response slot is free when empty or being drained this cycle
  assign wr_fire = aw_valid & w_valid & (~bvalid_q | s_axil_bready);
  assign rd_fire = ar_valid & (~rvalid_q | s_axil_rready);

  // Write path: response code and register next-state
  always_comb begin
    logic [31:0] merged;
    merged   = '0;
    gctrl_d  = gctrl_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    clr      = '0;

    case (wr_dec.tgt)
      T_GCTRL, T_CH_MODE, T_CH_PERIOD, T_CH_DUTY: wr_resp = OKAY;
      T_INFO, T_FREQ, T_CH_CNT:                   wr_resp = SLVERR;
      default:                                    wr_resp = DECERR;
    endcase

    // wstrb=0 is a legal no-op write; it must not disturb the counters
    if (wr_fire && (w_strb != 4'b0000)) begin
      if (wr_dec.tgt == T_GCTRL) begin
        merged  = apply_strb({31'b0, gctrl_q}, w_data, w_strb);
        gctrl_d = merged[0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_dec.ch == 6'(i)) begin
          case (wr_dec.tgt)
            T_CH_MODE: begin
              merged    = apply_strb({30'b0, mode_q[i]}, w_data, w_strb);
              mode_d[i] = merged[1:0];
              clr[i]    = 1'b1;
            end
            T_CH_PERIOD: begin
              merged      = apply_strb(32'(period_q[i]), w_data, w_strb);
              period_d[i] = CNT_WIDTH'(merged);
              clr[i]      = 1'b1;
            end
            T_CH_DUTY: begin
              merged    = apply_strb(32'(duty_q[i]), w_data, w_strb);
              duty_d[i] = CNT_WIDTH'(merged);
            end
            default: ;
          endcase
        end
      end
    end

    bvalid_d = wr_fire ? 1'b1 : (s_axil_bready ? 1'b0 : bvalid_q);
    bresp_d  = wr_fire ? wr_resp : bresp_q;
  end

  // Read path: sampled from current register state, so a same-cycle
  // write to the same register reads back the old value.
  always_comb begin
    rd_data = '0;
    rd_resp = (rd_dec.tgt == T_NONE) ? DECERR : OKAY;
    case (rd_dec.tgt)
      T_GCTRL: rd_data = {31'b0, gctrl_q};
      T_INFO:  rd_data = {16'b0, 8'(CNT_WIDTH), 8'(NUM_CH)};
      T_FREQ:  rd_data = 32'(CLK_FREQ);
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_dec.ch == 6'(i)) begin
        case (rd_dec.tgt)
          T_CH_MODE:   rd_data = {30'b0, mode_q[i]};
          T_CH_PERIOD: rd_data = 32'(period_q[i]);
          T_CH_DUTY:   rd_data = 32'(duty_q[i]);
          T_CH_CNT:    rd_data = 32'(cnt_w[i]);
          default: ;
        endcase
      end
    end

    rvalid_d = rd_fire ? 1'b1 : (s_axil_rready ? 1'b0 : rvalid_q);
    rresp_d  = rd_fire ? rd_resp : rresp_q;
    rdata_d  = rd_fire ? rd_data : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gctrl_q  <= 1'b0;
      mode_q   <= '0;
      period_q <= {NUM_CH{PERIOD_RST}};
      duty_q   <= {NUM_CH{DUTY_RST}};
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      gctrl_q  <= gctrl_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    blinky_pwm_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (gctrl_q),
      .clr_i    (clr[g]),
      .mode_i   (mode_t'(mode_q[g])),
      .period_i (period_q[g]),
      .duty_i   (duty_q[g]),
      .cnt_o    (cnt_w[g]),
      .led_o    (led[g])
    );
  end

endmodule

// File: tb/tb_blinky_pwm_reg.sv
// tb/tb_blinky_pwm_reg.sv - self-checking bench for blinky_pwm_reg
module tb_blinky_pwm_reg;

  localparam logic [1:0] R_OKAY   = 2'b00;
  localparam logic [1:0] R_SLVERR = 2'b10;
  localparam logic [1:0] R_DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  led;
  logic [7:0]  s_axil_awaddr;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic        s_axil_bvalid;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bready;
  logic [7:0]  s_axil_araddr;
  logic        s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  blinky_pwm_reg #(.CLK_FREQ(100_000_000), .NUM_CH(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .led(led),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rready(s_axil_rready)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All inputs change on the falling edge; ready/valid seen there hold until the next rising edge.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_pend, w_pend, aw_hs, w_hs, got;
    int n;
    resp = 2'bxx;
    s_axil_awaddr = a; s_axil_awvalid = 1'b1;
    s_axil_wdata = d; s_axil_wstrb = s; s_axil_wvalid = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 50) begin
      aw_hs = aw_pend && s_axil_awready;
      w_hs  = w_pend && s_axil_wready;
      @(negedge clk); n++;
      if (aw_hs) begin aw_pend = 1'b0; s_axil_awvalid = 1'b0; end
      if (w_hs)  begin w_pend = 1'b0;  s_axil_wvalid = 1'b0; end
    end
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      if (s_axil_bvalid) begin
        got = 1'b1; resp = s_axil_bresp;
      end else begin
        @(negedge clk); n++;
      end
    end
    if (!got) check("write response timeout", 32'(n), 32'd0);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [1:0] resp, output logic [31:0] data);
    logic pend, hs, got;
    int n;
    resp = 2'bxx; data = 'x;
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    pend = 1'b1; n = 0;
    while (pend && n < 50) begin
      hs = s_axil_arready;
      @(negedge clk); n++;
      if (hs) begin pend = 1'b0; s_axil_arvalid = 1'b0; end
    end
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      if (s_axil_rvalid) begin
        got = 1'b1; resp = s_axil_rresp; data = s_axil_rdata;
      end else begin
        @(negedge clk); n++;
      end
    end
    if (!got) check("read response timeout", 32'(n), 32'd0);
    s_axil_arvalid = 1'b0;
  endtask

  task automatic measure_blink(input int ch, input int cycles, input int exp_int, input string name);
    int last, toggles, bad;
    logic prev;
    last = -1; toggles = 0; bad = 0;
    prev = led[ch];
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (led[ch] !== prev) begin
        if (last >= 0 && (c - last) != exp_int) bad++;
        last = c; toggles++; prev = led[ch];
      end
    end
    check({name, " toggles>=3"}, 32'(toggles >= 3), 32'd1);
    check({name, " interval errors"}, 32'(bad), 32'd0);
  endtask

  task automatic count_high(input int ch, input int cycles, output int highs);
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (led[ch] === 1'b1) highs++;
    end
  endtask

  logic [1:0]  resp;
  logic [31:0] data;
  int          highs;
  logic [7:0]  wa [8];
  logic [1:0]  wexp [8];
  logic [7:0]  ra [8];
  logic [31:0] rexp_d [8];
  logic [1:0]  rexp_r [8];

  initial begin
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset led", 32'(led), 32'd0);
    check("reset awready", 32'(s_axil_awready), 32'd0);
    check("reset wready", 32'(s_axil_wready), 32'd0);
    check("reset arready", 32'(s_axil_arready), 32'd0);
    check("reset bvalid", 32'(s_axil_bvalid), 32'd0);
    check("reset rvalid", 32'(s_axil_rvalid), 32'd0);
    check("reset bresp", 32'(s_axil_bresp), 32'd0);
    check("reset rresp", 32'(s_axil_rresp), 32'd0);
    check("reset rdata", s_axil_rdata, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed register vectors (gctrl stays 0 here)
    vecs.push_back('{1'b0, 8'h01, 32'h0, 4'h0, R_OKAY, 32'h0000_2004});
    vecs.push_back('{1'b0, 8'h02, 32'h0, 4'h0, R_OKAY, 32'd100_000_000});
    vecs.push_back('{1'b0, 8'h10, 32'h0, 4'h0, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h11, 32'h0, 4'h0, R_OKAY, 32'd50_000_000});
    vecs.push_back('{1'b0, 8'h12, 32'h0, 4'h0, R_OKAY, 32'd25_000_000});
    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, R_OKAY, 32'h0});
    vecs.push_back('{1'b1, 8'h13, 32'h5, 4'hF, R_SLVERR, 32'h0});
    vecs.push_back('{1'b1, 8'h20, 32'h5, 4'hF, R_DECERR, 32'h0});
    vecs.push_back('{1'b0, 8'h05, 32'h0, 4'h0, R_DECERR, 32'h0});
    vecs.push_back('{1'b0, 8'h20, 32'h0, 4'h0, R_DECERR, 32'h0});
    vecs.push_back('{1'b0, 8'h13, 32'h0, 4'h0, R_OKAY, 32'h0});
    vecs.push_back('{1'b1, 8'h11, 32'h0, 4'hF, R_OKAY, 32'h0});
    vecs.push_back('{1'b1, 8'h11, 32'hAABB_CCDD, 4'b0010, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h11, 32'h0, 4'h0, R_OKAY, 32'h0000_CC00});
    vecs.push_back('{1'b1, 8'h11, 32'hFFFF_FFFF, 4'b0000, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h11, 32'h0, 4'h0, R_OKAY, 32'h0000_CC00});
    vecs.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0001, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h10, 32'h0, 4'h0, R_OKAY, 32'h3});
    vecs.push_back('{1'b1, 8'h10, 32'h0, 4'hF, R_OKAY, 32'h0});
    vecs.push_back('{1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0001, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, R_OKAY, 32'h1});
    vecs.push_back('{1'b1, 8'h00, 32'h0, 4'hF, R_OKAY, 32'h0});
    vecs.push_back('{1'b1, 8'h12, 32'h1234_5678, 4'b1100, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h12, 32'h0, 4'h0, R_OKAY, 32'h1234_7840});
    vecs.push_back('{1'b1, 8'h1E, 32'h55, 4'hF, R_OKAY, 32'h0});
    vecs.push_back('{1'b0, 8'h1E, 32'h0, 4'h0, R_OKAY, 32'h55});
    vecs.push_back('{1'b1, 8'h01, 32'h0, 4'hF, R_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 8'h01, 32'h0, 4'h0, R_OKAY, 32'h0000_2004});
    vecs.push_back('{1'b1, 8'h03, 32'h1, 4'hF, R_DECERR, 32'h0});
    vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, R_OKAY, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d bresp @%02h", i, vecs[i].addr), 32'(resp), 32'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, resp, data);
        check($sformatf("vec%0d rresp @%02h", i, vecs[i].addr), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("vec%0d rdata @%02h", i, vecs[i].addr), data, vecs[i].rdata);
      end
    end

    // Blink on ch0, period 4, then period 2 written mid-count
    axi_write(8'h11, 32'd4, 4'hF, resp);
    axi_write(8'h10, 32'd2, 4'hF, resp);
    axi_write(8'h00, 32'd1, 4'hF, resp);
    measure_blink(0, 26, 4, "blink p4");
    for (int c = 0; c < 20 && led[0] !== 1'b1; c++) @(negedge clk);
    check("blink led high before period write", 32'(led[0]), 32'd1);
    axi_write(8'h11, 32'd2, 4'hF, resp);
    check("period write clears led", 32'(led[0]), 32'd0);
    measure_blink(0, 16, 2, "blink p2");

    // PWM on ch1: period 10, duty 3, then duty 0 and duty 20
    axi_write(8'h15, 32'd10, 4'hF, resp);
    axi_write(8'h16, 32'd3, 4'hF, resp);
    axi_write(8'h14, 32'd3, 4'hF, resp);
    repeat (2) @(negedge clk);
    count_high(1, 40, highs);
    check("pwm duty3 highs/40", 32'(highs), 32'd12);
    axi_write(8'h16, 32'd0, 4'hF, resp);
    repeat (2) @(negedge clk);
    count_high(1, 20, highs);
    check("pwm duty0 highs/20", 32'(highs), 32'd0);
    axi_write(8'h16, 32'd20, 4'hF, resp);
    repeat (2) @(negedge clk);
    count_high(1, 20, highs);
    check("pwm duty20 highs/20", 32'(highs), 32'd20);

    // Back-to-back burst with random back-pressure
    for (int k = 0; k < 8; k++) begin
      case (k % 3)
        0:       begin wa[k] = 8'h1A; wexp[k] = R_OKAY;   end
        1:       begin wa[k] = 8'h13; wexp[k] = R_SLVERR; end
        default: begin wa[k] = 8'h40; wexp[k] = R_DECERR; end
      endcase
      case (k % 4)
        0:       begin ra[k] = 8'h01; rexp_r[k] = R_OKAY;   rexp_d[k] = 32'h0000_2004; end
        1:       begin ra[k] = 8'h02; rexp_r[k] = R_OKAY;   rexp_d[k] = 32'd100_000_000; end
        2:       begin ra[k] = 8'h05; rexp_r[k] = R_DECERR; rexp_d[k] = 32'h0; end
        default: begin ra[k] = 8'h15; rexp_r[k] = R_OKAY;   rexp_d[k] = 32'd10; end
      endcase
    end
    fork
      begin : p_aw
        int k, n;
        logic hs;
        k = 0; n = 0;
        s_axil_awaddr = wa[0]; s_axil_awvalid = 1'b1;
        while (k < 8 && n < 400) begin
          hs = s_axil_awready;
          @(negedge clk); n++;
          if (hs) begin
            k++;
            if (k < 8) s_axil_awaddr = wa[k]; else s_axil_awvalid = 1'b0;
          end
        end
        s_axil_awvalid = 1'b0;
        if (k < 8) check("burst aw accepted", 32'(k), 32'd8);
      end
      begin : p_w
        int k, n;
        logic hs;
        k = 0; n = 0;
        s_axil_wdata = 32'h100; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
        while (k < 8 && n < 400) begin
          hs = s_axil_wready;
          @(negedge clk); n++;
          if (hs) begin
            k++;
            if (k < 8) s_axil_wdata = 32'h100 + 32'(k); else s_axil_wvalid = 1'b0;
          end
        end
        s_axil_wvalid = 1'b0;
        if (k < 8) check("burst w accepted", 32'(k), 32'd8);
      end
      begin : p_ar
        int k, n;
        logic hs;
        k = 0; n = 0;
        s_axil_araddr = ra[0]; s_axil_arvalid = 1'b1;
        while (k < 8 && n < 400) begin
          hs = s_axil_arready;
          @(negedge clk); n++;
          if (hs) begin
            k++;
            if (k < 8) s_axil_araddr = ra[k]; else s_axil_arvalid = 1'b0;
          end
        end
        s_axil_arvalid = 1'b0;
        if (k < 8) check("burst ar accepted", 32'(k), 32'd8);
      end
      begin : p_b
        int k, n;
        k = 0; n = 0;
        while (k < 8 && n < 400) begin
          @(negedge clk); n++;
          s_axil_bready = 1'($urandom_range(0, 1));
          if (s_axil_bvalid && s_axil_bready) begin
            check($sformatf("burst bresp %0d", k), 32'(s_axil_bresp), 32'(wexp[k]));
            k++;
          end
        end
        s_axil_bready = 1'b1;
        if (k < 8) check("burst b count", 32'(k), 32'd8);
      end
      begin : p_r
        int k, n;
        logic hold;
        logic [31:0] held;
        k = 0; n = 0; hold = 1'b0; held = '0;
        while (k < 8 && n < 400) begin
          @(negedge clk); n++;
          if (hold) begin
            check("burst rvalid held", 32'(s_axil_rvalid), 32'd1);
            check("burst rdata stable", s_axil_rdata, held);
          end
          s_axil_rready = 1'($urandom_range(0, 1));
          hold = s_axil_rvalid && !s_axil_rready;
          held = s_axil_rdata;
          if (s_axil_rvalid && s_axil_rready) begin
            check($sformatf("burst rresp %0d", k), 32'(s_axil_rresp), 32'(rexp_r[k]));
            check($sformatf("burst rdata %0d", k), s_axil_rdata, rexp_d[k]);
            k++;
          end
        end
        s_axil_rready = 1'b1;
        if (k < 8) check("burst r count", 32'(k), 32'd8);
      end
    join
    axi_read(8'h1A, resp, data);
    check("burst last duty write", data, 32'h106);

    // Reset asserted with a write and a read in flight
    @(negedge clk);
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    s_axil_awaddr = 8'h1A; s_axil_wdata = 32'h77; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    s_axil_araddr = 8'h01; s_axil_arvalid = 1'b1;
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset bvalid", 32'(s_axil_bvalid), 32'd1);
    check("pre-reset rvalid", 32'(s_axil_rvalid), 32'd1);
    check("pre-reset led1", 32'(led[1]), 32'd1);
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async reset led", 32'(led), 32'd0);
    check("async reset bvalid", 32'(s_axil_bvalid), 32'd0);
    check("async reset rvalid", 32'(s_axil_rvalid), 32'd0);
    check("async reset rdata", s_axil_rdata, 32'd0);
    check("async reset awready", 32'(s_axil_awready), 32'd0);
    check("async reset arready", 32'(s_axil_arready), 32'd0);
    @(negedge clk);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      int spurious;
      spurious = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (s_axil_bvalid || s_axil_rvalid) spurious++;
      end
      check("no response for dropped transactions", 32'(spurious), 32'd0);
    end
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    axi_read(8'h00, resp, data);
    check("post-reset gctrl", data, 32'h0);
    axi_read(8'h15, resp, data);
    check("post-reset ch1 period", data, 32'd50_000_000);
    axi_read(8'h1A, resp, data);
    check("post-reset ch2 duty", data, 32'd25_000_000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blinky_pwm_reg.md
# blinky_pwm_reg

Memory-mapped multi-channel LED controller with an AXI-Lite slave register port. It is the parametrised successor of the single-channel blinky register block. `NUM_CH` independent channels each run in off, solid, blink or PWM mode, with per-channel period and duty registers. Writes honour byte strobes. The block sits behind the debug bridge / AXI-Lite interconnect and drives board LEDs directly.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency in Hz, readable at 0x02.
- `NUM_CH`, 4: channel count, 1..8.
- `CNT_WIDTH`, 32: width of the period, duty and counter fields, 8..32. Readback is zero-extended to 32 bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `led` out NUM_CH: channel outputs, registered.
- `s_axil_awaddr` in 8, `s_axil_awvalid` in 1, `s_axil_awready` out 1: write address.
- `s_axil_wdata` in 32, `s_axil_wstrb` in 4, `s_axil_wvalid` in 1, `s_axil_wready` out 1: write data.
- `s_axil_bvalid` out 1, `s_axil_bresp` out 2, `s_axil_bready` in 1: write response.
- `s_axil_araddr` in 8, `s_axil_arvalid` in 1, `s_axil_arready` out 1: read address.
- `s_axil_rvalid` out 1, `s_axil_rdata` out 32, `s_axil_rresp` out 2, `s_axil_rready` in 1: read data.

## Operation
- Addresses are register indices (one 32-bit word per address), matching the existing blinky map.
- Global registers:
  - 0x00 RW `gctrl`: bit0 master enable. When 0, all `led` are 0 and all counters are held at 0.
  - 0x01 RO `info`: [7:0]=NUM_CH, [15:8]=CNT_WIDTH.
  - 0x02 RO `CLK_FREQ`.
- Channel i registers (base 0x10+4·i):
  - +0 RW `mode[1:0]`: 0 off, 1 solid, 2 blink, 3 pwm.
  - +1 RW `period`.
  - +2 RW `duty`.
  - +3 RO `cnt`.
- Channel counter behaviour:
  - Effective period is P = max(period, 1).
  - In blink or pwm mode, `cnt` counts 0..P-1 and then wraps.
  - If `cnt` ≥ P-1, including after `period` is lowered below `cnt`, the next value is 0.
  - In off and solid modes, `cnt` is held at 0.
- LED output per mode:
  - off: `led`=0.
  - solid: `led`=1.
  - blink: `led` toggles on each wrap.
  - pwm: `led` = (cnt < duty). duty=0 gives always off; duty ≥ P gives always on.
- Writes:
  - A write completes when AW and W are both held and either bvalid=0 or bready=1.
  - Only bytes with their `wstrb` bit set are updated. `wstrb`=0 is legal: OKAY response, no change.
  - Bits beyond CNT_WIDTH, and reserved bits, are dropped.
  - Writing `mode` or `period` of channel i clears its `cnt` and forces `led`[i]=0 on the next cycle.
- Write responses: OKAY 00 for RW targets; SLVERR 10 for RO targets (no state change); DECERR 11 for unmapped addresses, including channel bases at or beyond NUM_CH.
- Reads: rresp is OKAY or DECERR. Unmapped reads return rdata=0.

## Timing
- Reset values:
  - Outputs: `led`=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0. awready, wready and arready are 0 during reset.
  - Registers: gctrl=0, every mode=0, period=CLK_FREQ/2 truncated to CNT_WIDTH, duty=period/2, cnt=0.
- AW, W and AR each pass through a 2-entry skid buffer, so ready is registered.
- Throughput: one write per cycle and one read per cycle, concurrently, while responses are drained.
- Latency:
  - Register update and bvalid are asserted 1 cycle after AW and W are consumed from the skid buffers.
  - rvalid and rdata are asserted 1 cycle after AR is consumed.
- rdata, rresp and bresp stay stable while their valid is high and ready is low.
- A same-cycle read and write to the same register returns the old value.
- `cnt` readback is the value at AR-consume time.
- `led` changes 1 cycle after the counter event that causes it.
- Reset asserted mid-transaction drops all in-flight transactions and restores the reset values asynchronously. No response is issued for the dropped transactions.

## Structure
- Package `blinky_pkg`:
  - `mode_t` enum.
  - Register offset constants: GCTRL, INFO, FREQ, CH_BASE=0x10, CH_STRIDE=4, CH_MODE, CH_PERIOD, CH_DUTY, CH_CNT.
  - AXI response constants: OKAY, SLVERR, DECERR.
- Sub-module `blinky_pwm_chan`: one instance per channel via generate. Contains the counter, wrap logic and LED register. Inputs are mode, period, duty, enable and clr.
- Reuse the existing skid-buffer module on AW, W and AR.

## Test plan
- Reset, then read 0x01 and 0x02 -> rdata=0x0000_2004 and CLK_FREQ, both OKAY. Read 0x10 -> 0.
- gctrl=1; ch0 mode=2, period=4 -> led[0] toggles every 4 cycles. Write period=2 mid-count -> cnt clears, then led[0] toggles every 2 cycles.
- ch1 mode=3, period=10, duty=3 -> led[1] is high 3 of every 10 cycles. duty=0 -> constant 0. duty=20 -> constant 1.
- Write 0xAABBCCDD to ch0 period with wstrb=0010 after period=0 -> period reads back 0x0000_CC00.
- Write to 0x13 -> SLVERR. Write to 0x20 with NUM_CH=4 -> DECERR. Read 0x05 -> DECERR with rdata=0. State is unchanged in all three cases.
- Back-to-back 8 writes and 8 reads with bready/rready toggled randomly -> all responses arrive in order, none are lost. Assert rst mid-burst -> all outputs return to reset values immediately.
